// File: rtl/timer_digit_entry.sv
// timer_digit_entry: keypad digit entry for an MM:SS countdown timer.
// Digit keys shift in from the right, KEY_CLEAR wipes the entry and
// KEY_START commits it to the countdown stage, which must acknowledge.
// Optional feature macro: TIMER_SEC_CLAMP_EN clamps seconds above 59 to 59
// on commit. When the macro is undefined, digits are committed unmodified.
module timer_digit_entry #(
    parameter logic [3:0] KEY_CLEAR = 4'hA,
    parameter logic [3:0] KEY_START = 4'hB
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       time_ack,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] digit_cnt,
    output logic       full,
    output logic       time_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [2:0] digit_cnt_q;
    logic       time_valid_q;
    logic       key_prev_q;

    logic       press_d;
    logic       is_digit_d;
    logic [3:0] sec_tens_commit_d;
    logic [3:0] sec_ones_commit_d;

    // Rising edge of the held-key level: one event per key press.
    assign press_d    = key_valid & ~key_prev_q;
    assign is_digit_d = (key_code <= 4'd9);

    // Seconds digits as they will be presented when the entry is committed.
`ifdef TIMER_SEC_CLAMP_EN
    assign sec_tens_commit_d = (sec_tens_q > 4'd5) ? 4'd5 : sec_tens_q;
    assign sec_ones_commit_d = (sec_tens_q > 4'd5) ? 4'd9 : sec_ones_q;
`else
    assign sec_tens_commit_d = sec_tens_q;
    assign sec_ones_commit_d = sec_ones_q;
`endif

    // Entry FSM: edge detect, digit shifting, clear, commit and handshake.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q      <= IDLE;
            min_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            sec_ones_q   <= 4'd0;
            digit_cnt_q  <= 3'd0;
            time_valid_q <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            // Always track the key level so a held key never retriggers,
            // even when its press is discarded.
            key_prev_q <= key_valid;
            case (state_q)
                LOCKED: begin
                    // Presses are ignored; only the acknowledge releases the lock.
                    if (time_ack) begin
                        state_q      <= IDLE;
                        min_tens_q   <= 4'd0;
                        min_ones_q   <= 4'd0;
                        sec_tens_q   <= 4'd0;
                        sec_ones_q   <= 4'd0;
                        digit_cnt_q  <= 3'd0;
                        time_valid_q <= 1'b0;
                    end
                end
                IDLE, ENTRY: begin
                    if (press_d) begin
                        if (key_code == KEY_CLEAR) begin
                            state_q     <= IDLE;
                            min_tens_q  <= 4'd0;
                            min_ones_q  <= 4'd0;
                            sec_tens_q  <= 4'd0;
                            sec_ones_q  <= 4'd0;
                            digit_cnt_q <= 3'd0;
                        end else if (key_code == KEY_START) begin
                            // Nothing to commit from IDLE.
                            if (state_q == ENTRY) begin
                                state_q      <= LOCKED;
                                time_valid_q <= 1'b1;
                                sec_tens_q   <= sec_tens_commit_d;
                                sec_ones_q   <= sec_ones_commit_d;
                            end
                        end else if (is_digit_d && (digit_cnt_q < 3'd4)) begin
                            state_q     <= ENTRY;
                            min_tens_q  <= min_ones_q;
                            min_ones_q  <= sec_tens_q;
                            sec_tens_q  <= sec_ones_q;
                            sec_ones_q  <= key_code;
                            digit_cnt_q <= digit_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign min_tens   = min_tens_q;
    assign min_ones   = min_ones_q;
    assign sec_tens   = sec_tens_q;
    assign sec_ones   = sec_ones_q;
    assign digit_cnt  = digit_cnt_q;
    assign time_valid = time_valid_q;
    assign full       = (digit_cnt_q == 3'd4);

endmodule

// File: tb/tb_timer_digit_entry.sv
// Directed bench for timer_digit_entry with hand-computed expectations.
module tb_timer_digit_entry;

    logic       clk;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_code;
    logic       time_ack;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] digit_cnt;
    logic       full;
    logic       time_valid;

    int n_vec;
    int n_miss;

    timer_digit_entry #(
        .KEY_CLEAR(4'hA),
        .KEY_START(4'hB)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .time_ack  (time_ack),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .digit_cnt (digit_cnt),
        .full      (full),
        .time_valid(time_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release any held key for one edge, then present a fresh press for one edge.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b0;
        tick();
        key_valid = 1'b1;
        key_code  = code;
        tick();
    endtask

    task automatic check_state(input string tag, input logic [15:0] digits,
                               input logic [2:0] cnt, input logic tv);
        check_val({tag, ".digits"}, {16'd0, min_tens, min_ones, sec_tens, sec_ones}, {16'd0, digits});
        check_val({tag, ".cnt"}, {29'd0, digit_cnt}, {29'd0, cnt});
        check_val({tag, ".full"}, {31'd0, full}, {31'd0, (cnt == 3'd4)});
        check_val({tag, ".tv"}, {31'd0, time_valid}, {31'd0, tv});
    endtask

    logic [15:0] exp_commit;

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        clr       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        time_ack  = 1'b0;
        tick();
        tick();
        check_state("reset", 16'h0000, 3'd0, 1'b0);
        clr = 1'b1;

        // Four digits shift in from the right, visible on the press edge.
        press(4'd1);
        check_state("d1", 16'h0001, 3'd1, 1'b0);
        press(4'd2);
        check_state("d2", 16'h0012, 3'd2, 1'b0);
        press(4'd3);
        press(4'd0);
        check_state("d4", 16'h1230, 3'd4, 1'b0);
        press(4'd7);
        check_state("overflow", 16'h1230, 3'd4, 1'b0);
        press(4'hC);
        check_state("code_c", 16'h1230, 3'd4, 1'b0);

        // Commit and handshake.
        press(4'hB);
        check_state("commit", 16'h1230, 3'd4, 1'b1);
        key_valid = 1'b0;
        time_ack  = 1'b1;
        tick();
        time_ack  = 1'b0;
        check_state("ack", 16'h0000, 3'd0, 1'b0);

        // A long hold yields exactly one digit.
        key_valid = 1'b1;
        key_code  = 4'd5;
        repeat (10) tick();
        check_state("hold5", 16'h0005, 3'd1, 1'b0);
        time_ack = 1'b1;
        tick();
        time_ack = 1'b0;
        check_state("ack_entry", 16'h0005, 3'd1, 1'b0);
        press(4'hA);
        check_state("clear", 16'h0000, 3'd0, 1'b0);
        press(4'hB);
        check_state("start_idle", 16'h0000, 3'd0, 1'b0);

        // Seconds clamp on commit depends on the build option.
        press(4'd9);
        press(4'd9);
        check_state("d99", 16'h0099, 3'd2, 1'b0);
`ifdef TIMER_SEC_CLAMP_EN
        exp_commit = 16'h0059;
`else
        exp_commit = 16'h0099;
`endif
        press(4'hB);
        check_state("commit99", exp_commit, 3'd2, 1'b1);
        press(4'd3);
        check_state("lock_digit", exp_commit, 3'd2, 1'b1);
        press(4'hA);
        check_state("lock_clear", exp_commit, 3'd2, 1'b1);

        // Press together with ack: ack wins, held key must not retrigger.
        key_valid = 1'b0;
        tick();
        key_valid = 1'b1;
        key_code  = 4'd9;
        time_ack  = 1'b1;
        tick();
        time_ack  = 1'b0;
        check_state("press_ack", 16'h0000, 3'd0, 1'b0);
        tick();
        check_state("press_ack_hold", 16'h0000, 3'd0, 1'b0);

        // Reset mid-entry, then normal entry resumes.
        press(4'd4);
        press(4'd2);
        check_state("d42", 16'h0042, 3'd2, 1'b0);
        key_valid = 1'b0;
        clr = 1'b0;
        tick();
        clr = 1'b1;
        check_state("midreset", 16'h0000, 3'd0, 1'b0);
        press(4'd3);
        check_state("after_reset", 16'h0003, 3'd1, 1'b0);

        // Key held through reset release presses once on the first clr=1 edge.
        key_valid = 1'b1;
        key_code  = 4'd7;
        clr       = 1'b0;
        tick();
        check_state("held_in_reset", 16'h0000, 3'd0, 1'b0);
        clr = 1'b1;
        tick();
        check_state("held_release", 16'h0007, 3'd1, 1'b0);
        tick();
        check_state("held_release2", 16'h0007, 3'd1, 1'b0);

        // Reset while locked.
        press(4'hB);
        check_state("commit7", 16'h0007, 3'd1, 1'b1);
        key_valid = 1'b0;
        clr = 1'b0;
        tick();
        clr = 1'b1;
        check_state("lock_reset", 16'h0000, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/timer_digit_entry.md
TIMER_DIGIT_ENTRY -- requirements
Module: timer_digit_entry

Interface
REQ-001 Parameter KEY_CLEAR, default 4'hA, key code that clears the entry.
REQ-002 Parameter KEY_START, default 4'hB, key code that commits the entry.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clr  input  1  reset; synchronous, active-low.
REQ-005 key_valid  input  1  level from the keypad encoder; high while a key is held.
REQ-006 key_code  input  4  code of the held key; valid while key_valid=1.
REQ-007 time_ack  input  1  countdown stage has taken the committed time.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits being entered (MM:SS).
REQ-009 digit_cnt  output  3  number of digits entered, 0-4.
REQ-010 full  output  1  high when digit_cnt==4.
REQ-011 time_valid  output  1  committed time on the digit outputs, held until acknowledged.

Function
REQ-012 The block SHALL register key_valid into key_prev each cycle; a press event is key_valid=1 and key_prev=0.
REQ-013 The block SHALL have exactly three states: IDLE (digit_cnt=0), ENTRY (1-4 digits), LOCKED (time_valid=1).
REQ-014 A press event with key_code 0-9 in IDLE or ENTRY with digit_cnt<4 SHALL shift {min_tens,min_ones,sec_tens,sec_ones} <= {min_ones,sec_tens,sec_ones,key_code} and increment digit_cnt, state ENTRY.
REQ-015 All outputs SHALL update at the same clock edge at which the press event is sampled (latency 1 edge from key_valid rising).
REQ-016 A digit press with digit_cnt==4 SHALL be ignored; digits, count and full stay unchanged.
REQ-017 A KEY_CLEAR press in IDLE or ENTRY SHALL zero all digits and digit_cnt and go to IDLE; in LOCKED it SHALL be ignored.
REQ-018 A KEY_START press in ENTRY SHALL go to LOCKED with time_valid=1 from the same edge; in IDLE or LOCKED it SHALL be ignored.
REQ-019 Key codes 4'hC-4'hF, and KEY_CLEAR/KEY_START when not matched by REQ-017/018, SHALL have no effect.
REQ-020 In LOCKED all press events SHALL be ignored; digits and time_valid SHALL hold.
REQ-021 time_ack=1 sampled in LOCKED SHALL, on that edge, clear time_valid, zero all digits and digit_cnt, and return to IDLE.
REQ-022 time_ack outside LOCKED SHALL be ignored.
REQ-023 A press event and time_ack in the same LOCKED cycle: ack SHALL be taken, the press discarded; key_prev still updates so a held key does not retrigger.
REQ-024 A key held across many cycles SHALL produce exactly one press event.
REQ-025 full SHALL equal (digit_cnt==4) combinationally from registered state.

Reset
REQ-026 clr=0 at a rising edge SHALL set all digits to 0, digit_cnt=0, full=0, time_valid=0, key_prev=0, state IDLE, overriding all other inputs including mid-entry and LOCKED.
REQ-027 A key held through reset release SHALL produce one press event on the first edge with clr=1.

Configuration
REQ-028 Macro TIMER_SEC_CLAMP_EN defined: on a KEY_START commit with sec_tens>5, sec_tens SHALL be set to 5 and sec_ones to 9 on the commit edge.
REQ-029 Macro TIMER_SEC_CLAMP_EN undefined: digits SHALL be committed unmodified.

Verification
REQ-030 Reset, then press 1,2,3,0 -> digits 1,2:3,0, digit_cnt=4, full=1.
REQ-031 With 4 digits, press 7 -> unchanged (12:30); press KEY_START -> time_valid=1 same edge; pulse time_ack -> next edge time_valid=0, digits 00:00, digit_cnt=0.
REQ-032 Hold key 5 for 10 cycles -> sec_ones=5, digit_cnt=1 only; press KEY_CLEAR -> all zero, IDLE.
REQ-033 In IDLE press KEY_START -> time_valid stays 0; in LOCKED press 9 together with time_ack -> IDLE, digits 00:00, no digit entered.
REQ-034 Enter 9,9 then KEY_START -> with TIMER_SEC_CLAMP_EN sec 5,9; without 9,9.
REQ-035 Enter 4,2 then clr=0 for one cycle -> all outputs reset values; pressing 3 afterwards -> sec_ones=3, digit_cnt=1.
